lfsr_rand_server: RTL and testbench
===================================

# lfsr_rand_server

Shared random-number server for the LBM datapath: owns one 56-bit XNOR LFSR and hands out one pseudo-random word per cycle to up to NUM_REQ requesters under round-robin arbitration. It handles seeding, an all-ones lock-up guard and a warm-up period after every (re)seed. Collision/noise units request words here rather than each instantiating a private generator.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WARMUP_CYCLES, 64, LFSR steps discarded after reset or reseed (1..255)
- DEFAULT_SEED, 56'hA5A5_5A5A_C3C3_3C, seed applied at reset
- Clk  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- seed_load  in  1  one-cycle pulse: load seed_in and restart warm-up
- seed_in  in  56  new seed, sampled when seed_load=1
- req  in  NUM_REQ  request per requester; level, held until granted
- gnt  out  NUM_REQ  one-hot grant pulse, registered
- rand_out  out  56  random word, valid in the cycle gnt is nonzero
- ready  out  1  high when warm-up has completed (SERVE state)

## Operation
- LFSR step: feedback = (s[22] ~^ s[21]) ~^ (s[1] ~^ s[0]); next = {feedback, s[55:1]}. Advances only on grant cycles and every warm-up cycle; holds otherwise.
- Lock-up guard: all-ones is the XNOR lock state. A seed of 56'hFF..FF (from seed_in or DEFAULT_SEED) is replaced by DEFAULT_SEED with bit 0 cleared.
- States: WARMUP, SERVE.
  - WARMUP: LFSR steps every cycle; counter counts 0..WARMUP_CYCLES-1; on the last count -> SERVE. No grants; ready=0.
  - SERVE: ready=1; arbitrate every cycle.
- Arbitration: round-robin. Pointer = index after last granted requester (reset 0). Scanning from the pointer, the first asserted req wins. At most one grant per cycle.
- Grant cycle: gnt[i]=1 and rand_out = LFSR state before the step; the LFSR steps once; the pointer moves to i+1 mod NUM_REQ.
- A req still high the cycle after its gnt is a new request and competes normally.
- seed_load (any state, any cycle): LFSR <- guarded seed_in, counter <- 0, state -> WARMUP. It beats a grant in the same cycle: no gnt is issued, and the pointer is unchanged.
- Arithmetic: warm-up counter is $clog2(WARMUP_CYCLES+1) bits and never wraps. Pointer is $clog2(NUM_REQ) bits with explicit mod wrap.

## Timing
- Reset values: gnt=0, rand_out=0, ready=0, state=WARMUP, counter=0, pointer=0, LFSR=guarded DEFAULT_SEED.
- After Reset deasserts, ready rises at the edge ending warm-up, WARMUP_CYCLES cycles later.
- Latency: req sampled at edge N -> gnt/rand_out visible after edge N+1 (one registered cycle). Sustained single requester gets a grant every cycle.
- rand_out holds its last value when gnt=0. Consumers qualify rand_out with gnt.
- seed_load at edge N: ready falls after edge N+1. The first grant is possible WARMUP_CYCLES+1 cycles after the seed_load edge.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). Any pending grant is dropped.

## Structure
- Package lfsr_rand_pkg: LFSR_W=56, tap constants (22, 21, 1, 0), DEFAULT_SEED, lock-up constant, function lfsr_step(s) and function seed_guard(s), state enum {WARMUP, SERVE}.
- Sub-module rr_arbiter (parameter N): req, enable and pointer in; one-hot grant and winner index out; combinational. The server registers its outputs.
- LFSR register lives in lfsr_rand_server, since it needs step-enable and synchronous load.

## Test plan
- Reset, no req: ready=0 for exactly 64 cycles, then 1. gnt stays 0 and rand_out stays 0 throughout.
- Single requester 2 held high after ready: gnt[2] every cycle. Successive rand_out values match a bench lfsr_step model started from DEFAULT_SEED advanced 64 steps.
- All four req high: grant order 0,1,2,3,0,1. Then drop req[1]: order continues 2,3,0,2,3,0.
- seed_load with seed_in=56'hFF_FFFF_FFFF_FFFF while req[0] high: no gnt that cycle. LFSR is loaded with the guarded seed, and the first rand_out equals the guarded seed advanced 64 steps.
- seed_load with seed_in=56'h1 mid-stream: ready low 64 cycles. Output sequence restarts and matches the model from 56'h1 advanced 64 steps, independent of prior history.
- Reset asserted between edges during SERVE with gnt[3] high: gnt, rand_out and ready go to 0 without a clock edge. After release, the warm-up repeats and the pointer restarts at 0.

Source files
------------

// File: rtl/lfsr_rand_server_pkg.sv
// Shared constants, types and helpers for the LFSR random-number server.
// Holds the XNOR LFSR step and the lock-up seed guard.
package lfsr_rand_pkg;

  localparam int LFSR_W = 56;

  localparam int TAP_A = 22;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 56'hA5A5_5A5A_C3C3_3C;
  localparam logic [LFSR_W-1:0] LOCKUP = {LFSR_W{1'b1}};

  typedef enum logic {
    WARMUP,
    SERVE
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] s
  );
    logic fb;
    fb = (s[TAP_A] ~^ s[TAP_B]) ~^ (s[TAP_C] ~^ s[TAP_D]);
    return {fb, s[LFSR_W-1:1]};
  endfunction

  // All-ones never leaves the XNOR lock state, so swap in a safe seed.
  function automatic logic [LFSR_W-1:0] seed_guard(
    input logic [LFSR_W-1:0] s,
    input logic [LFSR_W-1:0] dflt
  );
    return (s == LOCKUP) ? {dflt[LFSR_W-1:1], 1'b0} : s;
  endfunction

endpackage

// File: rtl/lfsr_rand_server_if.sv
// Request/grant and seeding bundle between the server and its clients.
// master = requester side, slave = server side.
interface lfsr_rand_server_if #(
  parameter int NUM_REQ = 4
);
  import lfsr_rand_pkg::*;

  logic               seed_load;
  logic [LFSR_W-1:0]  seed_in;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [LFSR_W-1:0]  rand_out;
  logic               ready;

  modport master (
    output seed_load, seed_in, req,
    input  gnt, rand_out, ready
  );

  modport slave (
    input  seed_load, seed_in, req,
    output gnt, rand_out, ready
  );

endinterface

// File: rtl/lfsr_rand_server_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr, first req wins.
// Emits a one-hot grant plus the winner index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_server.sv
// Shared 56-bit XNOR LFSR server with warm-up and round-robin grants.
// One word per cycle; seed_load restarts warm-up and beats any grant.
module lfsr_rand_server #(
  parameter int NUM_REQ       = 4,
  parameter int WARMUP_CYCLES = 64,
  parameter logic [55:0] DEFAULT_SEED = lfsr_rand_pkg::DEFAULT_SEED
) (
  input  logic          Clk,
  input  logic          Reset,
  lfsr_rand_server_if.slave bus
);
  import lfsr_rand_pkg::*;

  localparam int CW = $clog2(WARMUP_CYCLES + 1);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [LFSR_W-1:0] SEED_RST =
    seed_guard(DEFAULT_SEED, DEFAULT_SEED);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [LFSR_W-1:0]  rand_q, rand_d;

  logic               arb_en;
  logic               arb_any;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_idx;

  assign arb_en = (state_q == SERVE) && !bus.seed_load;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req (bus.req),
    .en  (arb_en),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= WARMUP;
      cnt_q   <= '0;
      ptr_q   <= '0;
      lfsr_q  <= SEED_RST;
      gnt_q   <= '0;
      rand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      lfsr_q  <= lfsr_d;
      gnt_q   <= gnt_d;
      rand_q  <= rand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    lfsr_d  = lfsr_q;
    gnt_d   = '0;
    rand_d  = rand_q;
    if (bus.seed_load) begin
      lfsr_d  = seed_guard(bus.seed_in, DEFAULT_SEED);
      cnt_d   = '0;
      state_d = WARMUP;
    end else begin
      unique case (state_q)
        WARMUP: begin
          lfsr_d = lfsr_step(lfsr_q);
          // Counter parks on its last value instead of wrapping.
          if (cnt_q == CW'(WARMUP_CYCLES - 1)) state_d = SERVE;
          else cnt_d = cnt_q + 1'b1;
        end
        SERVE: begin
          if (arb_any) begin
            gnt_d  = arb_gnt;
            rand_d = lfsr_q;
            lfsr_d = lfsr_step(lfsr_q);
            ptr_d  = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rand_out = rand_q;
  assign bus.ready    = (state_q == SERVE);

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Directed bench for lfsr_rand_server: warm-up, round-robin order,
// seeding, lock-up guard and asynchronous reset.
module tb_lfsr_rand_server;

  localparam int NREQ = 4;
  localparam int WU   = 64;
  localparam logic [55:0] DSEED = 56'hA5A5_5A5A_C3C3_3C;
  localparam logic [55:0] GSEED = 56'hA5A5_5A5A_C3C3_3C;

  logic Clk;
  logic Reset;
  int   n_tests;
  int   n_fail;
  logic [55:0] m;
  logic [55:0] last_rand;

  lfsr_rand_server_if #(.NUM_REQ(NREQ)) bus ();

  lfsr_rand_server #(
    .NUM_REQ       (NREQ),
    .WARMUP_CYCLES (WU),
    .DEFAULT_SEED  (DSEED)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [55:0] mstep(input logic [55:0] s);
    logic fb;
    fb = ~(s[22] ^ s[21] ^ s[1] ^ s[0]);
    return {fb, s[55:1]};
  endfunction

  function automatic logic [55:0] madv(input logic [55:0] s, input int n);
    logic [55:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = mstep(t);
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic warm(input string tag, input logic [55:0] hold);
    for (int c = 1; c <= WU; c++) begin
      tick();
      check({tag, "_ready"}, 64'(bus.ready), 64'(c == WU));
      check({tag, "_gnt"}, 64'(bus.gnt), 64'd0);
      check({tag, "_hold"}, 64'(bus.rand_out), 64'(hold));
    end
  endtask

  task automatic grant(input string tag, input int i);
    tick();
    check({tag, "_gnt"}, 64'(bus.gnt), 64'(1 << i));
    check({tag, "_rand"}, 64'(bus.rand_out), 64'(m));
    last_rand = m;
    m = mstep(m);
  endtask

  int ord_a[6] = '{0, 1, 2, 3, 0, 1};
  int ord_b[6] = '{2, 3, 0, 2, 3, 0};
  int ord_c[4] = '{1, 3, 1, 3};

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    Reset         = 1'b1;
    bus.req       = '0;
    bus.seed_load = 1'b0;
    bus.seed_in   = '0;
    last_rand     = '0;
    repeat (3) tick();
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_rand", 64'(bus.rand_out), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd0);
    @(negedge Clk) Reset = 1'b0;
    warm("wu0", 56'd0);

    m = madv(DSEED, WU);
    bus.req = 4'b1111;
    foreach (ord_a[k]) grant("rr_all", ord_a[k]);
    bus.req = 4'b1101;
    foreach (ord_b[k]) grant("rr_drop1", ord_b[k]);
    bus.req = 4'b0100;
    repeat (5) grant("single2", 2);

    bus.req       = 4'b0001;
    bus.seed_in   = {56{1'b1}};
    bus.seed_load = 1'b1;
    tick();
    bus.seed_load = 1'b0;
    check("seedff_gnt", 64'(bus.gnt), 64'd0);
    check("seedff_ready", 64'(bus.ready), 64'd0);
    check("seedff_hold", 64'(bus.rand_out), 64'(last_rand));
    warm("wu_ff", last_rand);
    m = madv(GSEED, WU);
    repeat (3) grant("guard_seq", 0);

    bus.req       = 4'b1010;
    bus.seed_in   = 56'h1;
    bus.seed_load = 1'b1;
    tick();
    bus.seed_load = 1'b0;
    check("seed1_gnt", 64'(bus.gnt), 64'd0);
    check("seed1_ready", 64'(bus.ready), 64'd0);
    warm("wu_1", last_rand);
    m = madv(56'h1, WU);
    foreach (ord_c[k]) grant("seed1_seq", ord_c[k]);

    bus.req = 4'b1000;
    grant("pre_rst", 3);
    #2 Reset = 1'b1;
    #1;
    check("arst_gnt", 64'(bus.gnt), 64'd0);
    check("arst_rand", 64'(bus.rand_out), 64'd0);
    check("arst_ready", 64'(bus.ready), 64'd0);
    bus.req = 4'b1111;
    @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    warm("wu_rst", 56'd0);
    m = madv(DSEED, WU);
    grant("post_rst", 0);
    grant("post_rst", 1);
    grant("post_rst", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
